// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared constants, InputExc bit indices and unpacked-operand type for the add/sub pipeline
package fpaddsub_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int SHIFT_MAX_DEF = 26;
  localparam int EXC_ANAN = 4;
  localparam int EXC_BNAN = 3;
  localparam int EXC_AINF = 2;
  localparam int EXC_BINF = 1;
  localparam int EXC_ANY = 0;
  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             nan;
    logic             inf;
  } unpacked_t;
  function automatic logic [4:0] sat_shift(input logic [EXP_W-1:0] d, input int smax);
    return (int'(d) > smax) ? 5'(smax) : d[4:0];
  endfunction
endpackage

// File: rtl/fpaddsub_classify.sv
// fpaddsub_classify: splits one packed single into sign/effective exponent/significand and flags NaN/Inf; FTZ under FPADDSUB_FTZ_EN
module fpaddsub_classify
  import fpaddsub_pkg::*;
(
  input  logic [31:0] op_i,
  output unpacked_t   u_o
);
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] frac;
  logic             zexp;
  assign exp  = op_i[30:23];
  assign zexp = ~|exp;
`ifdef FPADDSUB_FTZ_EN
  assign frac = zexp ? '0 : op_i[22:0];
`else
  assign frac = op_i[22:0];
`endif
  // exp=0 shares exponent 1 with the smallest normals; the hidden bit tells them apart
  assign u_o.sgn = op_i[31];
  assign u_o.exp = zexp ? 8'd1 : exp;
  assign u_o.sig = {~zexp, frac};
  assign u_o.nan = (exp == EXP_MAX) & (|frac);
  assign u_o.inf = (exp == EXP_MAX) & ~(|frac);
endmodule

// File: rtl/fpaddsub_unpack_align.sv
// fpaddsub_unpack_align: two-stage classify/order pipeline feeding the add/sub aligner; FTZ via FPADDSUB_FTZ_EN
module fpaddsub_unpack_align
  import fpaddsub_pkg::*;
#(
  parameter int SHIFT_MAX = SHIFT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Sa,
  output logic        Sb,
  output logic        MaxAB,
  output logic [7:0]  CExp,
  output logic [4:0]  Shift,
  output logic [23:0] Mmax,
  output logic [23:0] Mmin,
  output logic        Opr,
  output logic        CtrlOut,
  output logic [4:0]  InputExc
);
  unpacked_t a_d, b_d, a1_q, b1_q, mx, mn;
  logic s1_valid_q, ctrl1_q, s2_adv, b_gt;
  logic out_valid_q, sa_q, sb_q, maxab_q, opr_q, ctrl_q;
  logic [7:0] cexp_q, diff;
  logic [4:0] shift_q, exc_q, exc_d;
  logic [23:0] mmax_q, mmin_q;
  fpaddsub_classify u_cls_a (.op_i(A), .u_o(a_d));
  fpaddsub_classify u_cls_b (.op_i(B), .u_o(b_d));
  assign s2_adv   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  // effective exponent with hidden bit orders exactly like raw {exp, frac}; ties keep A as max
  assign b_gt = {b1_q.exp, b1_q.sig} > {a1_q.exp, a1_q.sig};
  assign mx   = b_gt ? b1_q : a1_q;
  assign mn   = b_gt ? a1_q : b1_q;
  assign diff = mx.exp - mn.exp;
  always_comb begin
    exc_d = '0;
    exc_d[EXC_ANAN] = a1_q.nan;
    exc_d[EXC_BNAN] = b1_q.nan;
    exc_d[EXC_AINF] = a1_q.inf;
    exc_d[EXC_BINF] = b1_q.inf;
    exc_d[EXC_ANY]  = a1_q.nan | b1_q.nan | a1_q.inf | b1_q.inf;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      ctrl1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      maxab_q     <= 1'b0;
      cexp_q      <= '0;
      shift_q     <= '0;
      mmax_q      <= '0;
      mmin_q      <= '0;
      opr_q       <= 1'b0;
      ctrl_q      <= 1'b0;
      exc_q       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          a1_q    <= a_d;
          b1_q    <= b_d;
          ctrl1_q <= Ctrl;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sa_q    <= a1_q.sgn;
          sb_q    <= b1_q.sgn;
          maxab_q <= b_gt;
          cexp_q  <= mx.exp;
          shift_q <= sat_shift(diff, SHIFT_MAX);
          mmax_q  <= mx.sig;
          mmin_q  <= mn.sig;
          opr_q   <= ctrl1_q ^ a1_q.sgn ^ b1_q.sgn;
          ctrl_q  <= ctrl1_q;
          exc_q   <= exc_d;
        end
      end
    end
  end
  assign out_valid = out_valid_q;
  assign Sa        = sa_q;
  assign Sb        = sb_q;
  assign MaxAB     = maxab_q;
  assign CExp      = cexp_q;
  assign Shift     = shift_q;
  assign Mmax      = mmax_q;
  assign Mmin      = mmin_q;
  assign Opr       = opr_q;
  assign CtrlOut   = ctrl_q;
  assign InputExc  = exc_q;
endmodule

// File: tb/tb_fpaddsub_unpack_align.sv
// tb_fpaddsub_unpack_align: directed and random handshake traffic checked against a queue-based reference model
module tb_fpaddsub_unpack_align;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, Ctrl = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, Sa, Sb, MaxAB, Opr, CtrlOut;
  logic [31:0] A = '0, B = '0;
  logic [7:0] CExp;
  logic [4:0] Shift, InputExc;
  logic [23:0] Mmax, Mmin;
  logic [70:0] got, held;
  logic [70:0] q[$];
  logic acc;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fpaddsub_unpack_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Ctrl(Ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .Sa(Sa), .Sb(Sb), .MaxAB(MaxAB), .CExp(CExp), .Shift(Shift), .Mmax(Mmax),
    .Mmin(Mmin), .Opr(Opr), .CtrlOut(CtrlOut), .InputExc(InputExc)
  );
  assign got = {Sa, Sb, MaxAB, CExp, Shift, Mmax, Mmin, Opr, CtrlOut, InputExc};
  task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [70:0] model(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [31:0] x = a, y = b;
    int ea, eb, ma, mb, d;
    logic bgt;
    logic [4:0] exc;
`ifdef FPADDSUB_FTZ_EN
    if (x[30:23] == 0) x[22:0] = '0;
    if (y[30:23] == 0) y[22:0] = '0;
`endif
    ea = (x[30:23] == 0) ? 1 : int'(x[30:23]);
    eb = (y[30:23] == 0) ? 1 : int'(y[30:23]);
    ma = int'(x[22:0]) + ((x[30:23] == 0) ? 0 : (1 << 23));
    mb = int'(y[22:0]) + ((y[30:23] == 0) ? 0 : (1 << 23));
    bgt = y[30:0] > x[30:0];
    d = (ea > eb) ? ea - eb : eb - ea;
    if (d > 26) d = 26;
    exc[4] = (x[30:23] == 255) && (x[22:0] != 0);
    exc[3] = (y[30:23] == 255) && (y[22:0] != 0);
    exc[2] = (x[30:23] == 255) && (x[22:0] == 0);
    exc[1] = (y[30:23] == 255) && (y[22:0] == 0);
    exc[0] = exc[4] || exc[3] || exc[2] || exc[1];
    return {x[31], y[31], bgt, 8'(bgt ? eb : ea), 5'(d), 24'(bgt ? mb : ma), 24'(bgt ? ma : mb),
            c ^ x[31] ^ y[31], c, exc};
  endfunction
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c, input logic r);
    @(negedge clk);
    in_valid = v; A = a; B = b; Ctrl = c; out_ready = r;
    #1;
    if (q.size() == 0) check("idle_valid", 71'(out_valid), 71'(0));
    else if (out_valid) begin
      check("data", got, q[0]);
      if (r) void'(q.pop_front());
    end
    acc = v && in_ready;
    if (acc) q.push_back(model(a, b, c));
  endtask
  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic c);
    step(1'b1, a, b, c, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("lat1", 71'(out_valid), 71'(0));
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("lat2", 71'(out_valid), 71'(1));
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    check("drain", 71'(q.size()), 71'(0));
  endtask
  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    int k = $urandom_range(0, 7);
    e = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : (k == 2) ? 8'(120 + $urandom_range(0, 15)) : 8'($urandom);
    f = ($urandom_range(0, 3) == 0) ? '0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", 71'(out_valid), 71'(0));
    check("rst_data", got, 71'(0));
    check("rst_ready", 71'(in_ready), 71'(1));
    dir(32'h3F800000, 32'h40000000, 1'b0);
    check("p1_maxab", 71'(MaxAB), 71'(1));
    check("p1_cexp", 71'(CExp), 71'(8'h80));
    check("p1_shift", 71'(Shift), 71'(1));
    check("p1_mant", 71'({Mmax, Mmin}), 71'({24'h800000, 24'h800000}));
    check("p1_opr_exc", 71'({Opr, InputExc}), 71'(0));
    dir(32'h7FC00000, 32'h3F800000, 1'b0);
    check("nan_exc", 71'(InputExc), 71'(5'b10001));
    dir(32'hFF800000, 32'h3F800000, 1'b0);
    check("inf_exc", 71'(InputExc), 71'(5'b00101));
    dir(32'h4B800000, 32'h33800000, 1'b0);
    check("sat_shift", 71'({MaxAB, CExp, Shift}), 71'({1'b0, 8'h97, 5'd26}));
    dir(32'h40400000, 32'hC0400000, 1'b0);
    check("tie", 71'({MaxAB, Shift, Opr}), 71'({1'b0, 5'd0, 1'b1}));
`ifdef FPADDSUB_FTZ_EN
    dir(32'h00000001, 32'h00000000, 1'b0);
    check("ftz", 71'({Sa, Mmax, Mmin}), 71'(0));
`endif
    drain();
    step(1'b1, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0);
    check("bp_acc1", 71'(acc), 71'(1));
    step(1'b1, 32'h40800000, 32'h41000000, 1'b1, 1'b0);
    check("bp_acc2", 71'(acc), 71'(1));
    step(1'b1, 32'h42000000, 32'hC2000000, 1'b0, 1'b0);
    check("bp_acc3", 71'(acc), 71'(0));
    check("bp_ready", 71'(in_ready), 71'(0));
    held = got;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("bp_hold", got, held);
    drain();
    step(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    #1;
    check("mid_rst_valid", 71'(out_valid), 71'(0));
    check("mid_rst_data", got, 71'(0));
    check("mid_rst_ready", 71'(in_ready), 71'(1));
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpaddsub_unpack_align.md
Name: fpaddsub_unpack_align

Overview:
- Input-side counterpart of the add/sub round-and-pack stage.
- Accepts two packed IEEE-754 single-precision operands and an operation bit, classifies them, and produces the input exception vector that the round stage consumes.
- Orders operands by magnitude and computes the alignment shift.
- Two-stage registered pipeline with valid/ready handshakes at both ends; feeds the alignment shifter / significand adder.

Parameters:
- SHIFT_MAX, 26: saturation value for the alignment shift amount (covers 24-bit significand plus guard and round positions).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair this cycle
- A  in  32  packed operand A
- B  in  32  packed operand B
- Ctrl  in  1  operation: 0 add, 1 subtract
- out_valid  out  1  unpacked result present
- out_ready  in  1  downstream accepts the result
- Sa  out  1  sign of A
- Sb  out  1  sign of B
- MaxAB  out  1  1 when |B| > |A|
- CExp  out  8  exponent of the larger-magnitude operand
- Shift  out  5  alignment shift for the smaller operand, saturated to SHIFT_MAX
- Mmax  out  24  larger significand, hidden bit included
- Mmin  out  24  smaller significand, hidden bit included (unshifted)
- Opr  out  1  effective operation = Ctrl ^ Sa ^ Sb (1 = magnitude subtract)
- CtrlOut  out  1  registered Ctrl
- InputExc  out  5  {A NaN, B NaN, A Inf, B Inf, OR of bits 4:1}

Behaviour:
- Reset: rst_n low at a clk edge clears both stage valids. Every output register is cleared to 0, so out_valid=0 and all data outputs read 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: any in-flight data is discarded, with no output pulse.
- Stage 1 (classify), registered:
  - Fields are split.
  - Hidden bit = |exp.
  - An operand with exp=0 uses effective exponent 1.
  - NaN = exp 0xFF with nonzero fraction; Inf = exp 0xFF with zero fraction.
- Stage 2 (order), registered:
  - Magnitude compare on {exp, frac}. MaxAB=1 only when |B| strictly greater; ties select A as max.
  - Shift = effective exponent difference, saturated to SHIFT_MAX when the difference exceeds it.
- Latency: exactly 2 cycles from an accepted input to out_valid, with no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - A stage advances when it is empty or the next stage advances this cycle.
  - in_ready = ~s1_valid | stage-1 advance. It is combinational from out_ready; no combinational path exists from in_valid.
  - Output data is held stable while out_valid && ~out_ready.
  - With out_ready low, at most 2 pairs are buffered and in_ready deasserts.
  - Simultaneous accept and drain on a full pipe sustains full throughput.
- Exceptional operands:
  - Field and exponent computation proceed unchanged; InputExc flags them.
  - Downstream overflow logic uses InputExc[0].
  - Downstream invalid logic uses bits 4:3.
- Zero operands (exp=0, frac=0) are not exceptions.

Optional Feature:
- Macro: FPADDSUB_FTZ_EN.
- When defined, subnormal inputs (exp=0, frac≠0) are flushed to signed zero in stage 1: fraction forced to 0 and the sign kept.
- When undefined, subnormals pass with hidden bit 0 and effective exponent 1.

Decomposition:
- Shared package fpaddsub_pkg holds:
  - constants EXP_W=8, MAN_W=23, EXP_MAX=8'hFF, SHIFT_MAX default;
  - InputExc bit-index constants (EXC_ANAN=4, EXC_BNAN=3, EXC_AINF=2, EXC_BINF=1, EXC_ANY=0), shared with the round stage;
  - a packed struct for the unpacked operand {sgn, exp, sig[23:0], nan, inf}.
- One sub-module, fpaddsub_classify: combinational per-operand field split and NaN/Inf/subnormal detection, instantiated twice in stage 1.

Test Plan:
- A=0x3F800000, B=0x40000000, Ctrl=0, out_ready=1:
  - 2 cycles later out_valid=1, MaxAB=1, CExp=0x80, Shift=1.
  - Mmax=Mmin=0x800000, Opr=0, InputExc=0.
- A=0x7FC00000, B=0x3F800000: InputExc=5'b10001. Same with A=0xFF800000 → InputExc=5'b00101.
- A=0x4B800000, B=0x33800000 → Shift=26 (saturated from 48), MaxAB=0, CExp=0x97.
- Equal magnitudes, A=0x40400000, B=0xC0400000, Ctrl=0 → MaxAB=0, Shift=0, Opr=1.
- out_ready held low while 3 pairs are offered back-to-back:
  - 2 pairs are accepted, then in_ready=0.
  - Outputs stay stable.
  - After release, the pairs emerge in order with no loss or duplication.
- rst_n pulsed low one cycle after an accept → out_valid=0 and all outputs 0; in_ready=1 the next cycle. FTZ build: A=0x00000001 → Mmax/Mmin fraction 0, sign 0.
